// File: rtl/multicycle_control_if.sv
// multicycle_control_if
// Control bundle between the multicycle main control FSM and the datapath.
//   master : the controller (samples run/opcode/funct/mem_ready, drives controls)
//   slave  : the datapath side (drives run/opcode/funct/mem_ready, samples controls)
// Signals:
//   run, opcode[5:0], funct[5:0], mem_ready            datapath -> controller
//   pc_write, pc_write_cond, branch_ne, i_or_d,
//   mem_read, mem_write, ir_write, alu_src_a,
//   alu_src_b[1:0], alu_op[2:0], pc_source[1:0],
//   reg_write, reg_dst[1:0], mem_to_reg[1:0],
//   state[3:0], illegal_op                             controller -> datapath
interface multicycle_control_if;
  logic       run;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       branch_ne;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_source;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic [3:0] state;
  logic       illegal_op;

  modport master (
    input  run, opcode, funct, mem_ready,
    output pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
           ir_write, alu_src_a, alu_src_b, alu_op, pc_source, reg_write,
           reg_dst, mem_to_reg, state, illegal_op
  );

  modport slave (
    output run, opcode, funct, mem_ready,
    input  pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
           ir_write, alu_src_a, alu_src_b, alu_op, pc_source, reg_write,
           reg_dst, mem_to_reg, state, illegal_op
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control
// Moore main control FSM for a multi-cycle MIPS datapath with one shared
// memory port, an instruction register and a single reused ALU. Memory wait
// states are absorbed by holding in FETCH / MEM_RD / MEM_WR until mem_ready.
// Ports:
//   clk    rising-edge system clock
//   reset  asynchronous active-low reset
//   bus    multicycle_control_if.master (inputs run/opcode/funct/mem_ready,
//          all datapath controls, debug state and sticky illegal_op)
// Build option:
//   MULTICYCLE_JAL_EN  adds the JAL state (14); without it opcode 000011 is illegal.
//
// state        | meaning
// -------------+----------------------------------------------------------
// IDLE     (0) | halted, all controls low; run=1 starts fetching
// FETCH    (1) | read instruction at PC, PC+4 -> PC and IR load on mem_ready
// DECODE   (2) | branch target -> ALUOut, dispatch on opcode/funct
// MEM_ADDR (3) | rs + sign-ext imm -> ALUOut
// MEM_RD   (4) | load read at ALUOut, hold until mem_ready
// MEM_WB   (5) | MDR -> rt
// MEM_WR   (6) | store write at ALUOut, hold until mem_ready
// EXEC_R   (7) | rs op rt (funct decoded by the ALU control)
// R_WB     (8) | ALUOut -> rd
// BRANCH   (9) | rs - rt, conditional PC <- ALUOut
// JUMP    (10) | PC <- jump address
// EXEC_I  (11) | rs op imm for addi/andi/ori/lui
// I_WB    (12) | ALUOut -> rt
// JR      (13) | PC <- rs
// JAL     (14) | r31 <- PC (already PC+4), PC <- jump address
module multicycle_control #(
  parameter logic [5:0] JR_FUNCT     = 6'b001000,
  parameter logic [1:0] RA_INDEX_SEL = 2'b10
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    EXEC_R   = 4'd7,
    R_WB     = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    EXEC_I   = 4'd11,
    I_WB     = 4'd12,
    JR       = 4'd13
`ifdef MULTICYCLE_JAL_EN
    , JAL    = 4'd14
`endif
  } stateT;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;

  stateT stateQ, stateD;
  stateT afterInstr;
  logic  illegalQ;
  logic  setIllegal;

  // Instruction boundary: run=0 parks the FSM in IDLE instead of fetching.
  assign afterInstr     = bus.run ? FETCH : IDLE;
  assign bus.state      = stateQ;
  assign bus.illegal_op = illegalQ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ   <= IDLE;
      illegalQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      if (setIllegal) illegalQ <= 1'b1;
    end
  end

  always_comb begin
    stateD            = stateQ;
    setIllegal        = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.branch_ne     = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 3'b000;
    bus.pc_source     = 2'b00;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 2'b00;
    bus.mem_to_reg    = 2'b00;

    case (stateQ)
      IDLE: if (bus.run) stateD = FETCH;
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (bus.mem_ready) stateD = DECODE;
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        case (bus.opcode)
          OpRtype:                      stateD = (bus.funct == JR_FUNCT) ? JR : EXEC_R;
          OpLw, OpSw:                   stateD = MEM_ADDR;
          OpBeq, OpBne:                 stateD = BRANCH;
          OpJ:                          stateD = JUMP;
          OpAddi, OpAndi, OpOri, OpLui: stateD = EXEC_I;
`ifdef MULTICYCLE_JAL_EN
          OpJal:                        stateD = JAL;
`endif
          default: begin
            setIllegal = 1'b1;
            stateD     = IDLE;
          end
        endcase
      end
      MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        stateD        = (bus.opcode == OpLw) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        if (bus.mem_ready) stateD = MEM_WB;
      end
      MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 2'b01;
        stateD         = afterInstr;
      end
      MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        if (bus.mem_ready) stateD = afterInstr;
      end
      EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 3'b010;
        stateD        = R_WB;
      end
      R_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 2'b01;
        stateD        = afterInstr;
      end
      BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 3'b001;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        bus.branch_ne     = (bus.opcode == OpBne);
        stateD            = afterInstr;
      end
      JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        stateD        = afterInstr;
      end
      EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        case (bus.opcode)
          OpAndi:  bus.alu_op = 3'b100;
          OpOri:   bus.alu_op = 3'b011;
          OpLui:   bus.alu_op = 3'b101;
          default: bus.alu_op = 3'b000;
        endcase
        stateD = I_WB;
      end
      I_WB: begin
        bus.reg_write = 1'b1;
        stateD        = afterInstr;
      end
      JR: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b11;
        stateD        = afterInstr;
      end
`ifdef MULTICYCLE_JAL_EN
      JAL: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = RA_INDEX_SEL;
        bus.mem_to_reg = 2'b10;
        bus.pc_write   = 1'b1;
        bus.pc_source  = 2'b10;
        stateD         = afterInstr;
      end
`endif
      default: stateD = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_if bus();
  multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

  localparam logic [5:0] JR_F = 6'b001000;

  typedef struct packed {
    logic [3:0]  st;
    logic        ill;
    logic [19:0] outs;
  } expT;

  expT sbQ[$];
  int  checks = 0;
  int  errors = 0;
  bit  mIdle  = 1'b0;
  bit  mIll   = 1'b0;

  function automatic logic [19:0] pk(bit pw, bit pwc, bit bne, bit iod, bit mrd, bit mwr,
                                     bit irw, bit asa, logic [1:0] asb, logic [2:0] aop,
                                     logic [1:0] ps, bit rw, logic [1:0] rd, logic [1:0] m2r);
    return {pw, pwc, bne, iod, mrd, mwr, irw, asa, asb, aop, ps, rw, rd, m2r};
  endfunction

  function automatic logic [19:0] actOuts();
    return {bus.pc_write, bus.pc_write_cond, bus.branch_ne, bus.i_or_d, bus.mem_read,
            bus.mem_write, bus.ir_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            bus.pc_source, bus.reg_write, bus.reg_dst, bus.mem_to_reg};
  endfunction

  // Control word the state table prescribes for a state, given opcode and mem_ready.
  function automatic logic [19:0] modelOuts(int st, logic [5:0] op, bit mr);
    logic [2:0] iop;
    case (op)
      6'b001100: iop = 3'b100;
      6'b001101: iop = 3'b011;
      6'b001111: iop = 3'b101;
      default:   iop = 3'b000;
    endcase
    case (st)
      1:  return pk(mr,0,0,0,1,0,mr,0,2'b01,3'b000,2'b00,0,2'b00,2'b00);
      2:  return pk(0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00,0,2'b00,2'b00);
      3:  return pk(0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0,2'b00,2'b00);
      4:  return pk(0,0,0,1,1,0,0,0,2'b00,3'b000,2'b00,0,2'b00,2'b00);
      5:  return pk(0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,1,2'b00,2'b01);
      6:  return pk(0,0,0,1,0,1,0,0,2'b00,3'b000,2'b00,0,2'b00,2'b00);
      7:  return pk(0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0,2'b00,2'b00);
      8:  return pk(0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,1,2'b01,2'b00);
      9:  return pk(0,1,(op == 6'b000101),0,0,0,0,1,2'b00,3'b001,2'b01,0,2'b00,2'b00);
      10: return pk(1,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,0,2'b00,2'b00);
      11: return pk(0,0,0,0,0,0,0,1,2'b10,iop,2'b00,0,2'b00,2'b00);
      12: return pk(0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,1,2'b00,2'b00);
      13: return pk(1,0,0,0,0,0,0,0,2'b00,3'b000,2'b11,0,2'b00,2'b00);
      14: return pk(1,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,1,2'b10,2'b10);
      default: return 20'd0;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (sbQ.size() > 0) begin
      expT e;
      e = sbQ.pop_front();
      chk("state", 32'(bus.state), 32'(e.st));
      chk("illegal_op", 32'(bus.illegal_op), 32'(e.ill));
      chk($sformatf("outs(st%0d)", e.st), 32'(actOuts()), 32'(e.outs));
    end
  end

  // One clock: drive inputs, queue the expected response for this cycle.
  task automatic step(bit r, bit mr, int st);
    expT e;
    bus.run       = r;
    bus.mem_ready = mr;
    e.st   = 4'(st);
    e.ill  = mIll;
    e.outs = modelOuts(st, bus.opcode, mr);
    sbQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into its expected state walk.
  task automatic doInstr(logic [5:0] op, logic [5:0] fn, int fw, int mw, bit keepRun);
    int  seq[$];
    int  memSt = -1;
    bit  bad   = 1'b0;
    bus.opcode = op;
    bus.funct  = fn;
    if (mIdle) step(1'b1, rbit(), 0);
    for (int i = 0; i < fw; i++) step(1'b1, 1'b0, 1);
    step(1'b1, 1'b1, 1);
    case (op)
      6'b000000: begin
        if (fn == JR_F) seq.push_back(13);
        else begin seq.push_back(7); seq.push_back(8); end
      end
      6'b100011: begin seq.push_back(3); seq.push_back(4); seq.push_back(5); memSt = 4; end
      6'b101011: begin seq.push_back(3); seq.push_back(6); memSt = 6; end
      6'b000100, 6'b000101: seq.push_back(9);
      6'b000010: seq.push_back(10);
      6'b001000, 6'b001100, 6'b001101, 6'b001111: begin seq.push_back(11); seq.push_back(12); end
`ifdef MULTICYCLE_JAL_EN
      6'b000011: seq.push_back(14);
`endif
      default: bad = 1'b1;
    endcase
    step(keepRun, rbit(), 2);
    if (bad) begin
      mIll  = 1'b1;
      mIdle = 1'b1;
      return;
    end
    foreach (seq[k]) begin
      if (seq[k] == memSt) begin
        for (int i = 0; i < mw; i++) step(keepRun, 1'b0, seq[k]);
        step(keepRun, 1'b1, seq[k]);
      end else begin
        step(keepRun, rbit(), seq[k]);
      end
    end
    mIdle = !keepRun;
  endtask

  task automatic idleCycles(int n);
    if (mIdle) for (int i = 0; i < n; i++) step(1'b0, rbit(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pool [11];
    logic [5:0] op, fn;
    pool = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
             6'b001000, 6'b001100, 6'b001101, 6'b001111, 6'b000011};
    bus.run = 1'b1; bus.mem_ready = 1'b0; bus.opcode = 6'd0; bus.funct = 6'd0;
    #1;
    chk("reset_state", 32'(bus.state), 32'd0);
    chk("reset_outs", 32'(actOuts()), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("first_fetch", 32'(bus.state), 32'd1);
    // Asynchronous reset in the middle of FETCH.
    #2 reset = 1'b0;
    #1;
    chk("midfetch_reset_state", 32'(bus.state), 32'd0);
    chk("midfetch_reset_outs", 32'(actOuts()), 32'd0);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("refetch", 32'(bus.state), 32'd1);
    mIdle = 1'b0;

    doInstr(6'b100011, 6'd0, 2, 2, 1'b1);       // lw with waits
    doInstr(6'b000100, 6'd0, 0, 0, 1'b1);       // beq
    doInstr(6'b000101, 6'd0, 0, 0, 1'b1);       // bne
    doInstr(6'b000000, JR_F, 0, 0, 1'b1);       // jr
    doInstr(6'b000000, 6'b100000, 0, 0, 1'b1);  // add
    doInstr(6'b101011, 6'd0, 1, 3, 1'b1);       // sw
    doInstr(6'b000010, 6'd0, 0, 0, 1'b1);       // j
    doInstr(6'b111111, 6'd0, 0, 0, 1'b1);       // illegal
    idleCycles(3);
    doInstr(6'b001000, 6'd0, 0, 0, 1'b0);       // addi, run dropped
    idleCycles(2);
    doInstr(6'b000011, 6'd0, 0, 0, 1'b1);       // jal
    doInstr(6'b001111, 6'd0, 0, 0, 1'b1);       // lui

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else op = pool[$urandom_range(0, 10)];
      fn = ($urandom_range(0, 3) == 0) ? JR_F : 6'($urandom);
      doInstr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), ($urandom_range(0, 4) != 0));
      idleCycles($urandom_range(0, 2));
    end

    @(negedge clk);
    chk("scoreboard_drained", 32'(sbQ.size()), 32'd0);
    chk("illegal_seen", 32'(bus.illegal_op), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("illegal_cleared", 32'(bus.illegal_op), 32'd0);
    chk("final_reset_state", 32'(bus.state), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style main control FSM that sequences a multi-cycle MIPS datapath: one shared memory port for instructions and data, an instruction register, and a single ALU reused for PC+4, branch target and execute.
- Replaces the single-cycle combinational Control unit.
- Its outputs drive the PC-write enables, the memory address and data-source muxes, the IR load and the register-file write controls.
- Supports wait states on the memory port through a mem_ready handshake.

Parameters:
- JR_FUNCT, 6'b001000, R-type funct code decoded as jr.
- RA_INDEX_SEL, 2'b10, reg_dst encoding that selects register 31.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  1 = execute; 0 = halt at next instruction boundary
- opcode  in  6  IR[31:26], stable from DECODE until instruction end
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory completed current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if branch condition true
- branch_ne  out  1  1 = condition is !zero, 0 = zero
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load IR
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 = rt, 01 = 4, 10 = sign-ext imm, 11 = imm<<2
- alu_op  out  3  000 add, 001 sub, 010 funct, 011 or, 100 and, 101 lui
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump addr, 11 = rs
- reg_write  out  1  register-file write enable
- reg_dst  out  2  00 = rt, 01 = rd, 10 = r31
- mem_to_reg  out  2  00 = ALUOut, 01 = MDR, 10 = PC
- state  out  4  current state code, for debug
- illegal_op  out  1  sticky flag: unsupported opcode decoded

Behaviour:
- Reset: state = IDLE (0) asynchronously. All outputs are 0 in IDLE, and illegal_op is cleared.
- Outputs are a function of state only. The exceptions are ir_write and pc_write in FETCH, which are gated by mem_ready, and branch_ne, which is (opcode==000101) in BRANCH.
- Default for every signal not listed for a state: 0.
- State codes and behaviour:
  - IDLE = 0: all outputs 0. Go to FETCH when run = 1.
  - FETCH = 1: mem_read, alu_src_b = 01, add, pc_source = 00; ir_write = pc_write = mem_ready. Stay while mem_ready = 0; go to DECODE when mem_ready = 1.
  - DECODE = 2: alu_src_b = 11, add (branch target into ALUOut). Next state:
    - 000000 with funct = JR_FUNCT: JR.
    - other 000000: EXEC_R.
    - 100011 or 101011: MEM_ADDR.
    - 000100 or 000101: BRANCH.
    - 000010: JUMP.
    - 001000, 001100, 001101, 001111: EXEC_I.
    - 000011: JAL (only with the optional feature).
    - anything else: set illegal_op, go to IDLE.
  - MEM_ADDR = 3: alu_src_a = 1, alu_src_b = 10, add. Go to MEM_RD if lw, else MEM_WR.
  - MEM_RD = 4: mem_read, i_or_d = 1. Wait for mem_ready, then go to MEM_WB.
  - MEM_WB = 5: reg_write, reg_dst = 00, mem_to_reg = 01.
  - MEM_WR = 6: mem_write, i_or_d = 1. Wait for mem_ready.
  - EXEC_R = 7: alu_src_a = 1, alu_src_b = 00, alu_op = 010. Go to R_WB.
  - R_WB = 8: reg_write, reg_dst = 01, mem_to_reg = 00.
  - BRANCH = 9: alu_src_a = 1, alu_src_b = 00, sub, pc_write_cond, pc_source = 01.
  - JUMP = 10: pc_write, pc_source = 10.
  - EXEC_I = 11: alu_src_a = 1, alu_src_b = 10. alu_op is addi → 000, andi → 100, ori → 011, lui → 101. Go to I_WB.
  - I_WB = 12: reg_write, reg_dst = 00, mem_to_reg = 00.
  - JR = 13: pc_write, pc_source = 11.
  - JAL = 14: see Optional Feature.
- Instruction boundary: every transition whose target would be FETCH (from MEM_WB, MEM_WR, R_WB, BRANCH, JUMP, I_WB, JR, JAL) goes to IDLE instead if run = 0 in that cycle.
- Deasserting run mid-instruction never aborts the instruction.
- mem_read and mem_write are never both 1. mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.
- Instruction latency with mem_ready always 1:
  - lw: 5 cycles.
  - sw, R-type, I-type: 4 cycles.
  - beq/bne, j, jr, jal: 3 cycles.
- Each memory wait cycle adds 1 cycle.
- illegal_op stays 1 until reset. From IDLE, run = 1 restarts fetching.
- Unused state code 15 goes to IDLE.

Optional Feature:
- MULTICYCLE_JAL_EN defined: opcode 000011 goes DECODE → JAL. JAL state drives reg_write, reg_dst = 10, mem_to_reg = 10 (PC already holds PC+4), pc_write, pc_source = 10, then FETCH/IDLE.
- MULTICYCLE_JAL_EN undefined: state 14 does not exist and 000011 is treated as illegal.

Test Plan:
- Reset low mid-FETCH, run = 1: state = 0 and all outputs 0 immediately. After release, FETCH on the next edge.
- lw (opcode 100011) with mem_ready low 2 cycles in both FETCH and MEM_RD: states 1,1,1,2,3,4,4,4,5,1. reg_write = 1 only in 5, with mem_to_reg = 01.
- beq then bne, mem_ready = 1: states 1,2,9. branch_ne = 0, then 1; pc_write_cond = 1 and pc_source = 01 in state 9.
- R-type funct 001000: state 13 with pc_write = 1 and pc_source = 11. Funct 100000: states 7,8 with reg_dst = 01.
- Opcode 111111: illegal_op = 1 and state 0 after DECODE. It stays 1 after run toggles, and clears only on reset low.
- run dropped during EXEC_I (addi): I_WB completes with reg_write = 1, then state 0. jal is illegal without MULTICYCLE_JAL_EN; with it, state 14 shows reg_dst = 10 and mem_to_reg = 10.
